// File: rtl/bios_loader.sv
// Loads BIOS memories from a UART byte stream: 16-bit word-count header, then little-endian words.
// Define BIOS_LOADER_CHECKSUM_EN to expect and verify a trailing mod-256 payload checksum byte.
module bios_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_din,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_written
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
`ifdef BIOS_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_e;

`ifdef BIOS_LOADER_CHECKSUM_EN
  localparam state_e POST_ST = CSUM;
`else
  localparam state_e POST_ST = DONE;
`endif

  // One word more than the index range, so L == 2^ADDR_WIDTH is still legal.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [XLEN-1:0]   word_q, word_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [16:0]       idx_q, idx_d;
  logic              err_q, err_d;
  logic              accept;
  logic              in_csum;
`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
`ifdef BIOS_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
`ifdef BIOS_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
`ifdef BIOS_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LEN0;
          err_d   = 1'b0;
          idx_d   = '0;
          bcnt_d  = '0;
`ifdef BIOS_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d[15:8] = in_data;
          if ({1'b0, in_data, len_q[7:0]} > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if ({in_data, len_q[7:0]} == 16'd0) begin
            state_d = POST_ST;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d[8*bcnt_q +: 8] = in_data;
          bcnt_d = bcnt_q + 2'd1;
`ifdef BIOS_LOADER_CHECKSUM_EN
          csum_d = csum_q + in_data;
`endif
          if (bcnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_q + 17'd1;
        if (idx_d == {1'b0, len_q}) state_d = POST_ST;
        else                        state_d = DATA;
      end
`ifdef BIOS_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          if (in_data != csum_q) err_d = 1'b1;
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef BIOS_LOADER_CHECKSUM_EN
  assign in_csum = (state_q == CSUM);
`else
  assign in_csum = 1'b0;
`endif

  // Moore outputs: decoded from state or taken straight from registers.
  assign in_ready      = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA) || in_csum;
  assign mem_we        = (state_q == WRITE);
  assign busy          = in_ready || mem_we;
  assign done          = (state_q == DONE);
  assign error         = err_q;
  assign mem_addr      = idx_q[ADDR_WIDTH-1:0];
  assign mem_din       = word_q;
  assign words_written = idx_q[15:0];

endmodule

// File: doc/bios_loader.md
# bios_loader

Byte-stream loader that fills the BIOS instruction/data memories through their write port. It sits between the UART receiver (valid/ready byte stream) and the BIOS memory write side. It parses a length header, assembles little-endian 32-bit words, and issues one sequential write per word starting at word address 0. It reports `busy`, `done` and `error` to the control/CSR logic.

## Interface

Parameters:
- `ADDR_WIDTH`, default 12: word-address width; memory depth is 2^ADDR_WIDTH words (matches `BIOS_MEM_ADDR_WIDTH`).
- `XLEN`, default 32: word width. Only 32 is supported.

Ports:
- `clk`  input  1  clock; all logic on rising edge.
- `reset`  input  1  reset, synchronous, active-high.
- `start`  input  1  single-cycle pulse that arms a load; honoured only in IDLE or DONE.
- `in_data`  input  8  stream byte.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `mem_we`  output  1  write strobe, driving both the inst and data arrays.
- `mem_addr`  output  ADDR_WIDTH  word write address.
- `mem_din`  output  XLEN  write data.
- `busy`  output  1  load in progress.
- `done`  output  1  load finished; held until the next `start` or `reset`.
- `error`  output  1  header or checksum error; valid while `done`=1.
- `words_written`  output  16  count of `mem_we` pulses in the current load.

## Operation

- Byte transfer: a byte is accepted on a rising edge where `in_valid && in_ready`.
- Stream format:
  - length L, 16-bit little-endian word count (2 bytes);
  - then L words, each 4 bytes, LSB first;
  - then, with checksum enabled, 1 checksum byte.
- States:
  - IDLE: `in_ready`=0. `start` goes to LEN0.
  - LEN0: `in_ready`=1. Accepted byte goes to L[7:0]; next state LEN1.
  - LEN1: `in_ready`=1. Accepted byte goes to L[15:8], then:
    - L > 2^ADDR_WIDTH: set `error`, go to DONE; no writes; checksum byte not consumed.
    - L == 0: go to CSUM if enabled, else DONE.
    - Otherwise: go to DATA.
  - DATA: `in_ready`=1. A byte counter 0..3 places each byte at bits [8k+7:8k]. Accepting the 4th byte goes to WRITE.
  - WRITE: `in_ready`=0, `mem_we`=1 for exactly one cycle. The word index then increments and `words_written` increments. If the index equals L, go to CSUM (enabled) or DONE; else go to DATA.
  - CSUM: see Configuration.
  - DONE: `done`=1 and `busy`=0. `start` clears `done`, `error`, `words_written`, the word index and the checksum accumulator, then goes to LEN0.
- `busy`=1 in LEN0, LEN1, DATA, WRITE and CSUM.
- `start` is ignored while `busy`=1.
- `mem_addr` equals the current word index; with L == 2^ADDR_WIDTH the last write is to address 2^ADDR_WIDTH−1.
- Reset mid-operation aborts the load and returns to IDLE. Words already written are not erased.

## Timing

- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `busy`=0, `done`=0, `error`=0, `words_written`=0; state IDLE.
- All outputs are registered or decoded from state only (Moore). `in_ready` does not depend on `in_valid`.
- `start` in cycle n gives `busy`=1 and `in_ready`=1 in cycle n+1.
- The 4th byte of a word accepted at edge n gives `mem_we`=1 in cycle n+1. `mem_addr` and `mem_din` are stable during that cycle.
- Peak throughput: 5 cycles per word (4 accept cycles plus 1 write cycle).
- Without checksum, `done`=1 in the cycle after the final WRITE cycle.
- Gaps in `in_valid` only stall; state and partial words are retained.

## Configuration

- Macro: `BIOS_LOADER_CHECKSUM_EN`.
- Defined:
  - CSUM state present; `in_ready`=1 in CSUM.
  - A mod-256 sum of all payload bytes is kept; length bytes are excluded.
  - The accepted checksum byte is compared to the sum. On mismatch, `error` is set. Either way, go to DONE.
  - Words already written remain.
- Undefined: no CSUM state, no accumulator; the byte following the payload is not consumed, and `error` flags only the length overflow.

## Test plan

- Nominal: `start`, then stream 02 00 78 56 34 12 EF BE AD DE.
  - Required: `mem_we` at addr 0 with 0x12345678, then at addr 1 with 0xDEADBEEF.
  - Then `done`=1, `error`=0, `words_written`=2.
- Back-pressure: same stream with random `in_valid` gaps → identical writes. `in_ready`=0 in every WRITE cycle; no byte is lost or duplicated.
- Zero length: stream 00 00 (plus checksum 00 if enabled) → no `mem_we`, `done`=1, `error`=0.
- Overflow, ADDR_WIDTH=12: stream 01 10 (L=0x1001) → `done`=1, `error`=1, no `mem_we`. A subsequent `start` clears `error`.
- Checksum (macro defined), 1-word payload 78 56 34 12:
  - Checksum byte 0x14 → `error`=0.
  - Checksum byte 0x15 → `error`=1, and addr 0 still holds 0x12345678.
  - Macro undefined → `done` without consuming the extra byte.
- Reset mid-DATA: `reset` after 2 payload bytes → all outputs at reset values, state IDLE. A new `start` plus a full stream loads correctly from addr 0.
